izh_neuron_update: RTL
======================

// Module: izh_neuron_update
// PURPOSE
//  Per-timestep Izhikevich membrane update engine feeding compute_in_memory (CIM).
//  Walks neurons 0..NUMNEURONS-1, reads each synaptic current from CIM, Euler-updates v/u (1 ms).
//  Fired neurons have their tag pushed into the spike FIFO that CIM drains.
//  After the FIFO drains and CIM is idle, issues one swap pulse to close the timestep.
// PARAMETERS
//  NUMWIDTH  16      value width-1; v, u, I are NUMWIDTH+1-bit signed, Q8.8
//  TAGBITS   5       neuron tag width
//  NUMNEURONS 2**TAGBITS  neuron count
//  FRAC      8       fractional bits
//  A         5       recovery rate a (0.0195, Q8.8)
//  B         51      sensitivity b (0.199, Q8.8)
//  C         -16640  reset potential c (-65.0)
//  D         2048    reset increment d (8.0)
//  VPEAK     7680    spike threshold (30.0)
// PORTS
//  clk          in   1           clock
//  reset        in   1           synchronous, active-high
//  tick_start   in   1           begin one timestep (sampled in IDLE only)
//  busy         out  1           1 whenever state != IDLE
//  tick_done    out  1           1-cycle pulse, timestep complete
//  read_en      out  1           CIM current-read strobe
//  i_tag        out  TAGBITS     neuron whose current is requested
//  i_in         in   NUMWIDTH+1  CIM current (i_out), signed Q8.8
//  spike_wr     out  1           FIFO push strobe
//  spike_tag    out  TAGBITS     tag of fired neuron
//  fifo_full    in   1           spike FIFO full
//  fifo_empty   in   1           spike FIFO empty
//  cim_busy     in   1           CIM busy
//  swap         out  1           1-cycle pulse to CIM: i <= i_next
//  spike_count  out  TAGBITS+1   spikes emitted this timestep
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> IDLE; n=0; every v[k]=C, u[k]=(B*C)>>>FRAC=-3315.
//  Reset mid-timestep aborts it; no swap, no tick_done.
//  States: IDLE, ISSUE, WAIT, CAPTURE, COMMIT, SYNC, SWAP, DONE.
//  IDLE: on tick_start -> ISSUE, n=0, spike_count=0. tick_start outside IDLE is ignored.
//  ISSUE (T): read_en=1, i_tag=n -> WAIT. WAIT (T+1) -> CAPTURE.
//   CIM read latency is 2 clocks: i_in is valid in CAPTURE (T+2). i_tag stays n until COMMIT exits.
//  CAPTURE: register I=i_in, v=v[n], u=u[n], compute (>>> is arithmetic, >= 40-bit intermediates):
//   dv = ((((v*v)>>>FRAC)*41)>>>10) + 5*v + (140<<<FRAC) - u + I
//   du = (A*(((B*v)>>>FRAC) - u))>>>FRAC   (uses old v)
//   vn = sat(v+dv), un = sat(u+du); sat clamps to [-2^NUMWIDTH, 2^NUMWIDTH-1].
//   fire = (vn >= VPEAK). -> COMMIT.
//  COMMIT (T+3):
//   If fire && fifo_full: stall in COMMIT, no write, spike_wr=0.
//   Else: write v[n]=fire?C:vn and u[n]=fire?sat(un+D):un.
//   If fire: spike_wr=1 for exactly 1 cycle, spike_tag=n, spike_count++.
//   Then if n==NUMNEURONS-1 -> SYNC, else n++ and -> ISSUE.
//   Unstalled throughput: 4 clocks/neuron.
//  SYNC: wait until fifo_empty && !cim_busy, sampled the same cycle -> SWAP. A new push is impossible here.
//  SWAP: swap=1 for exactly 1 cycle -> DONE. DONE: tick_done=1 for 1 cycle -> IDLE.
//  spike_count holds its value until the next tick_start.
//  n wraps to 0 only through IDLE.
//  spike_wr and swap are never asserted in the same cycle.
// TESTING
//  1 Reset, tick_start, all I=0 -> v[0]=-17379, u[0]=-3315, no spike_wr; swap pulse once,
//    then tick_done, spike_count=0.
//  2 I[3]=0x0FFFF, others 0 -> vn=48156, fires: spike_wr with spike_tag=3 at neuron 3's COMMIT;
//    v[3]=-16640, u[3]=-1267, spike_count=1.
//  3 Neuron 5 fires while fifo_full=1 for 6 cycles -> stays in COMMIT 6 extra cycles;
//    exactly one spike_wr once full drops; neuron 6 is read afterwards.
//  4 Hold cim_busy=1 for 10 cycles after the last COMMIT -> FSM stays in SYNC, swap=0;
//    swap is 1 cycle after cim_busy falls (fifo_empty=1).
//  5 Assert reset during neuron 10's WAIT -> next cycle busy=0, all outputs 0;
//    v[0..9] restored to -16640.
//  6 Read timing: read_en at T with i_tag=n; model CIM drives i_in only at T+2
//    -> captured value matches; tick_start while busy is ignored.

Source files
------------

// File: rtl/izh_neuron_update.sv
// ---------------------------------------------------------------------------
// izh_neuron_update
//   Per-timestep Izhikevich membrane update engine for the compute-in-memory
//   (CIM) array. Each timestep walks neurons 0..NUMNEURONS-1:
//   1. Reads the neuron's synaptic current from CIM.
//   2. Euler-updates v/u in Q8.8.
//   3. Pushes the tag of every neuron that fires into the spike FIFO.
//   When the FIFO has drained and CIM is idle, one swap pulse closes the
//   timestep.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   tick_start_i    start one timestep (only honoured in IDLE)
//   busy_o          engine is inside a timestep
//   tick_done_o     one-cycle pulse when the timestep is complete
//   read_en_o       CIM current-read strobe; i_tag_o selects the neuron
//   i_in_i          CIM current, valid two clocks after read_en_o
//   spike_wr_o      FIFO push strobe; spike_tag_o is the fired neuron
//   fifo_full_i     spike FIFO full
//   fifo_empty_i    spike FIFO empty
//   cim_busy_i      CIM busy
//   swap_o          one-cycle pulse to CIM to promote i_next into i
//   spike_count_o   spikes emitted in the current/last timestep
//
// spike_wr_o is the only output decoded combinationally. It is qualified by
// fifo_full_i in the same cycle, so a push can never land on a full FIFO.
// ---------------------------------------------------------------------------
module izh_neuron_update #(
   parameter int unsigned NUMWIDTH   = 16,
   parameter int unsigned TAGBITS    = 5,
   parameter int unsigned NUMNEURONS = 2**TAGBITS,
   parameter int unsigned FRAC       = 8,
   parameter int          A          = 5,
   parameter int          B          = 51,
   parameter int          C          = -16640,
   parameter int          D          = 2048,
   parameter int          VPEAK      = 7680
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     tick_start_i,
   output logic                     busy_o,
   output logic                     tick_done_o,
   output logic                     read_en_o,
   output logic [TAGBITS-1:0]       i_tag_o,
   input  logic signed [NUMWIDTH:0] i_in_i,
   output logic                     spike_wr_o,
   output logic [TAGBITS-1:0]       spike_tag_o,
   input  logic                     fifo_full_i,
   input  logic                     fifo_empty_i,
   input  logic                     cim_busy_i,
   output logic                     swap_o,
   output logic [TAGBITS:0]         spike_count_o
);

   localparam int unsigned VW = NUMWIDTH + 1;
   localparam int unsigned XW = 48;
   localparam int unsigned CW = TAGBITS + 1;

   localparam logic signed [XW-1:0] SAT_HI  = XW'((longint'(1) <<< NUMWIDTH) - longint'(1));
   localparam logic signed [XW-1:0] SAT_LO  = XW'(-(longint'(1) <<< NUMWIDTH));
   localparam logic signed [XW-1:0] A_X     = XW'(A);
   localparam logic signed [XW-1:0] B_X     = XW'(B);
   localparam logic signed [XW-1:0] D_X     = XW'(D);
   localparam logic signed [XW-1:0] VPEAK_X = XW'(VPEAK);
   localparam logic signed [VW-1:0] V_RST   = VW'(C);
   localparam logic signed [VW-1:0] U_RST   = VW'((longint'(B) * longint'(C)) >>> FRAC);
   localparam logic [TAGBITS-1:0]   LAST_N  = TAGBITS'(NUMNEURONS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_COMMIT, S_SYNC, S_SWAP, S_DONE
   } state_t;

   state_t                   state_q;
   logic [TAGBITS-1:0]       n_q;
   logic signed [VW-1:0]     v_q [NUMNEURONS];
   logic signed [VW-1:0]     u_q [NUMNEURONS];
   logic signed [VW-1:0]     vn_q, un_q;
   logic                     fire_q;
   logic                     busy_q, tick_done_q, read_en_q, swap_q;
   logic [TAGBITS-1:0]       i_tag_q, spike_tag_q;
   logic [CW-1:0]            spike_count_q;

   logic signed [XW-1:0]     v_x, u_x, i_x, dv_x, du_x;
   logic signed [VW-1:0]     vn_d, un_d, ukick_d;
   logic                     fire_d;

   // Clamp a wide intermediate into the signed value range.
   function automatic logic signed [VW-1:0] sat(input logic signed [XW-1:0] x);
      if (x > SAT_HI) begin
         return VW'(SAT_HI);
      end else if (x < SAT_LO) begin
         return VW'(SAT_LO);
      end
      return VW'(x);
   endfunction

   // Euler step for the neuron currently addressed by n_q, using the live CIM current.
   always_comb begin
      v_x     = XW'(v_q[n_q]);
      u_x     = XW'(u_q[n_q]);
      i_x     = XW'(i_in_i);
      dv_x    = ((((v_x * v_x) >>> FRAC) * XW'(41)) >>> 10) + (XW'(5) * v_x)
              + (XW'(140) <<< FRAC) - u_x + i_x;
      du_x    = (A_X * (((B_X * v_x) >>> FRAC) - u_x)) >>> FRAC;
      vn_d    = sat(v_x + dv_x);
      un_d    = sat(u_x + du_x);
      fire_d  = (XW'(vn_d) >= VPEAK_X);
      ukick_d = sat(XW'(un_q) + D_X);
   end

   // Timestep sequencer, state memory and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         n_q           <= '0;
         vn_q          <= '0;
         un_q          <= '0;
         fire_q        <= 1'b0;
         busy_q        <= 1'b0;
         tick_done_q   <= 1'b0;
         read_en_q     <= 1'b0;
         swap_q        <= 1'b0;
         i_tag_q       <= '0;
         spike_tag_q   <= '0;
         spike_count_q <= '0;
         for (int unsigned k = 0; k < NUMNEURONS; k++) begin
            v_q[TAGBITS'(k)] <= V_RST;
            u_q[TAGBITS'(k)] <= U_RST;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (tick_start_i) begin
                  state_q       <= S_ISSUE;
                  n_q           <= '0;
                  i_tag_q       <= '0;
                  spike_count_q <= '0;
                  busy_q        <= 1'b1;
                  read_en_q     <= 1'b1;
               end
            end
            S_ISSUE: begin
               read_en_q <= 1'b0;
               state_q   <= S_WAIT;
            end
            S_WAIT: begin
               state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               // CIM read data is valid in this cycle (two clocks after the strobe).
               vn_q        <= vn_d;
               un_q        <= un_d;
               fire_q      <= fire_d;
               spike_tag_q <= n_q;
               state_q     <= S_COMMIT;
            end
            S_COMMIT: begin
               // A firing neuron waits here until the FIFO can take its tag.
               if (!(fire_q && fifo_full_i)) begin
                  v_q[n_q] <= fire_q ? V_RST : vn_q;
                  u_q[n_q] <= fire_q ? ukick_d : un_q;
                  if (fire_q) begin
                     spike_count_q <= spike_count_q + CW'(1);
                  end
                  if (n_q == LAST_N) begin
                     state_q <= S_SYNC;
                  end else begin
                     n_q       <= n_q + TAGBITS'(1);
                     i_tag_q   <= n_q + TAGBITS'(1);
                     read_en_q <= 1'b1;
                     state_q   <= S_ISSUE;
                  end
               end
            end
            S_SYNC: begin
               if (fifo_empty_i && !cim_busy_i) begin
                  swap_q  <= 1'b1;
                  state_q <= S_SWAP;
               end
            end
            S_SWAP: begin
               swap_q      <= 1'b0;
               tick_done_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               tick_done_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign tick_done_o   = tick_done_q;
   assign read_en_o     = read_en_q;
   assign i_tag_o       = i_tag_q;
   assign spike_tag_o   = spike_tag_q;
   assign swap_o        = swap_q;
   assign spike_count_o = spike_count_q;
   assign spike_wr_o    = (state_q == S_COMMIT) && fire_q && !fifo_full_i;

endmodule
